// File: rtl/cam_capture_packer.sv
// Camera capture packer: samples a parallel camera bus in the system clock
// domain, packs byte pairs into 16-bit FIFO words and tracks lines per frame.
// Optional macro CAPTURE_SEQ_CHECK_EN enables the incrementing-byte checker
// driving seq_err; without it seq_err is tied low.
module cam_capture_packer #(
    parameter int unsigned LINE_BYTES = 320,
    parameter int unsigned LINE_W     = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cam_pclk,
    input  logic              cam_hsync,
    input  logic              cam_vsync,
    input  logic [7:0]        cam_data,
    input  logic              capture_en,
    input  logic              wr_full,
    output logic [15:0]       wr_data,
    output logic              wr_en,
    output logic              frame_done,
    output logic [LINE_W-1:0] line_count,
    output logic              overflow,
    output logic              seq_err
);

    localparam int unsigned CNT_W = $clog2(LINE_BYTES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE, DONE} state_e;

    state_e             state_q,      state_d;
    logic [2:0]         pclk_sync_q,  pclk_sync_d;
    logic [2:0]         hsync_sync_q, hsync_sync_d;
    logic [2:0]         vsync_sync_q, vsync_sync_d;
    logic [7:0]         data_s1_q,    data_s1_d;
    logic [7:0]         data_s2_q,    data_s2_d;
    logic               phase_q,      phase_d;
    logic [7:0]         hi_byte_q,    hi_byte_d;
    logic [CNT_W-1:0]   byte_cnt_q,   byte_cnt_d;
    logic [15:0]        wr_data_q,    wr_data_d;
    logic               wr_en_q,      wr_en_d;
    logic               frame_done_q, frame_done_d;
    logic [LINE_W-1:0]  line_count_q, line_count_d;
    logic               overflow_q,   overflow_d;
`ifdef CAPTURE_SEQ_CHECK_EN
    logic               seq_err_q,    seq_err_d;
    logic [7:0]         prev_byte_q,  prev_byte_d;
    logic               have_prev_q,  have_prev_d;
`endif

    logic hsync_s;
    logic pclk_rise;
    logic hsync_fall;
    logic vsync_rise;
    logic vsync_fall;
    logic take_byte;

    // Edge detection on the synchronized camera controls
    assign hsync_s    = hsync_sync_q[1];
    assign pclk_rise  = pclk_sync_q[1]  & ~pclk_sync_q[2];
    assign hsync_fall = ~hsync_sync_q[1] & hsync_sync_q[2];
    assign vsync_rise = vsync_sync_q[1]  & ~vsync_sync_q[2];
    assign vsync_fall = ~vsync_sync_q[1] & vsync_sync_q[2];
    assign take_byte  = pclk_rise & hsync_s & (byte_cnt_q < CNT_W'(LINE_BYTES));

    // Next-state, packing and status logic
    always_comb begin
        state_d      = state_q;
        pclk_sync_d  = {pclk_sync_q[1:0],  cam_pclk};
        hsync_sync_d = {hsync_sync_q[1:0], cam_hsync};
        vsync_sync_d = {vsync_sync_q[1:0], cam_vsync};
        data_s1_d    = cam_data;
        data_s2_d    = data_s1_q;
        phase_d      = phase_q;
        hi_byte_d    = hi_byte_q;
        byte_cnt_d   = byte_cnt_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        frame_done_d = 1'b0;
        line_count_d = line_count_q;
        overflow_d   = overflow_q;
`ifdef CAPTURE_SEQ_CHECK_EN
        seq_err_d    = seq_err_q;
        prev_byte_d  = prev_byte_q;
        have_prev_d  = have_prev_q;
`endif

        case (state_q)
            IDLE: begin
                if (capture_en) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (vsync_fall) begin
                    state_d      = ACTIVE;
                    line_count_d = '0;
                    overflow_d   = 1'b0;
                    phase_d      = 1'b0;
                    byte_cnt_d   = '0;
`ifdef CAPTURE_SEQ_CHECK_EN
                    seq_err_d    = 1'b0;
                    have_prev_d  = 1'b0;
`endif
                end
            end
            ACTIVE: begin
                if (take_byte) begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (!phase_q) begin
                        hi_byte_d = data_s2_q;
                        phase_d   = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (wr_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = {hi_byte_q, data_s2_q};
                        end
                    end
`ifdef CAPTURE_SEQ_CHECK_EN
                    if (have_prev_q && (data_s2_q != (prev_byte_q + 8'd1))) seq_err_d = 1'b1;
                    prev_byte_d = data_s2_q;
                    have_prev_d = 1'b1;
`endif
                end
                // Line end drops any odd byte; count saturates at all-ones
                if (hsync_fall) begin
                    if ((byte_cnt_q != '0) && (line_count_q != '1)) begin
                        line_count_d = line_count_q + LINE_W'(1);
                    end
                    phase_d    = 1'b0;
                    byte_cnt_d = '0;
                end
                if (vsync_rise) begin
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                    phase_d      = 1'b0;
                    byte_cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = capture_en ? WAIT_FRAME : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            pclk_sync_q  <= '0;
            hsync_sync_q <= '0;
            vsync_sync_q <= '0;
            data_s1_q    <= '0;
            data_s2_q    <= '0;
            phase_q      <= 1'b0;
            hi_byte_q    <= '0;
            byte_cnt_q   <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            line_count_q <= '0;
            overflow_q   <= 1'b0;
`ifdef CAPTURE_SEQ_CHECK_EN
            seq_err_q    <= 1'b0;
            prev_byte_q  <= '0;
            have_prev_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pclk_sync_q  <= pclk_sync_d;
            hsync_sync_q <= hsync_sync_d;
            vsync_sync_q <= vsync_sync_d;
            data_s1_q    <= data_s1_d;
            data_s2_q    <= data_s2_d;
            phase_q      <= phase_d;
            hi_byte_q    <= hi_byte_d;
            byte_cnt_q   <= byte_cnt_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            line_count_q <= line_count_d;
            overflow_q   <= overflow_d;
`ifdef CAPTURE_SEQ_CHECK_EN
            seq_err_q    <= seq_err_d;
            prev_byte_q  <= prev_byte_d;
            have_prev_q  <= have_prev_d;
`endif
        end
    end

    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign frame_done = frame_done_q;
    assign line_count = line_count_q;
    assign overflow   = overflow_q;
`ifdef CAPTURE_SEQ_CHECK_EN
    assign seq_err    = seq_err_q;
`else
    assign seq_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cam_capture_packer.sv
// Testbench for cam_capture_packer: two instances (LINE_BYTES 320 and 4) fed
// the same camera stream, checked against a byte-level scoreboard model.
module tb_cam_capture_packer;

    logic        clock;
    logic        reset;
    logic        cam_pclk;
    logic        cam_hsync;
    logic        cam_vsync;
    logic [7:0]  cam_data;
    logic        capture_en;
    logic        wr_full;

    logic [15:0] wd [2];
    logic        we [2];
    logic        fd [2];
    logic [9:0]  lc [2];
    logic        ov [2];
    logic        se [2];

    int checks   = 0;
    int failures = 0;

    // scoreboard model state, index 0 = 320-byte DUT, 1 = 4-byte DUT
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    int          m_lim   [2];
    int          m_cnt   [2];
    bit          m_phase [2];
    logic [7:0]  m_hi    [2];
    int          m_lines [2];
    bit          m_ovf   [2];
    bit          armed;
    int          fd_cnt  [2];

`ifdef CAPTURE_SEQ_CHECK_EN
    localparam logic EXP_SEQ = 1'b1;
`else
    localparam logic EXP_SEQ = 1'b0;
`endif

    cam_capture_packer #(.LINE_BYTES(320), .LINE_W(10)) dut_a (
        .clock(clock), .reset(reset), .cam_pclk(cam_pclk), .cam_hsync(cam_hsync),
        .cam_vsync(cam_vsync), .cam_data(cam_data), .capture_en(capture_en),
        .wr_full(wr_full), .wr_data(wd[0]), .wr_en(we[0]), .frame_done(fd[0]),
        .line_count(lc[0]), .overflow(ov[0]), .seq_err(se[0])
    );

    cam_capture_packer #(.LINE_BYTES(4), .LINE_W(10)) dut_b (
        .clock(clock), .reset(reset), .cam_pclk(cam_pclk), .cam_hsync(cam_hsync),
        .cam_vsync(cam_vsync), .cam_data(cam_data), .capture_en(capture_en),
        .wr_full(wr_full), .wr_data(wd[1]), .wr_en(we[1]), .frame_done(fd[1]),
        .line_count(lc[1]), .overflow(ov[1]), .seq_err(se[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write monitor: every strobe must match the oldest expected word
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (fd[i] === 1'b1) fd_cnt[i]++;
            if (we[i] === 1'b1) begin
                logic [15:0] exp_w;
                checks++;
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    failures++;
                    $display("FAIL write dut%0d: unexpected word %h at %0t", i, wd[i], $time);
                end else begin
                    exp_w = (i == 0) ? q0.pop_front() : q1.pop_front();
                    if (wd[i] !== exp_w) begin
                        failures++;
                        $display("FAIL write dut%0d: got %h expected %h", i, wd[i], exp_w);
                    end
                end
            end
        end
    end

    task automatic model_byte(input logic [7:0] b, input bit full);
        if (!armed) return;
        for (int i = 0; i < 2; i++) begin
            if (m_cnt[i] < m_lim[i]) begin
                m_cnt[i]++;
                if (!m_phase[i]) begin
                    m_hi[i]    = b;
                    m_phase[i] = 1'b1;
                end else begin
                    m_phase[i] = 1'b0;
                    if (full) m_ovf[i] = 1'b1;
                    else if (i == 0) q0.push_back({m_hi[i], b});
                    else q1.push_back({m_hi[i], b});
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit full);
        @(negedge clock);
        cam_pclk = 1'b0;
        cam_data = b;
        wr_full  = full;
        model_byte(b, full);
        repeat (3) @(negedge clock);
        cam_pclk = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic line_begin();
        @(negedge clock);
        cam_hsync = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic line_end();
        @(negedge clock);
        cam_pclk  = 1'b0;
        cam_hsync = 1'b0;
        wr_full   = 1'b0;
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                if (m_cnt[i] > 0) m_lines[i]++;
                m_cnt[i]   = 0;
                m_phase[i] = 1'b0;
            end
        end
        repeat (8) @(negedge clock);
    endtask

    task automatic send_line(input logic [7:0] start, input int n, input int full_idx);
        line_begin();
        for (int k = 0; k < n; k++) send_byte(8'(start + 8'(k)), k == full_idx);
        line_end();
    endtask

    task automatic frame_start();
        @(negedge clock);
        cam_vsync = 1'b1;
        repeat (8) @(negedge clock);
        cam_vsync = 1'b0;
        armed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_phase[i] = 1'b0; m_lines[i] = 0; m_ovf[i] = 1'b0;
        end
        repeat (8) @(negedge clock);
    endtask

    task automatic frame_end();
        @(negedge clock);
        cam_vsync = 1'b1;
        armed = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            checks += 6;
            if (wd[i] !== 16'h0) begin failures++; $display("FAIL reset_wr_data dut%0d: got %h expected 0000", i, wd[i]); end
            if (we[i] !== 1'b0) begin failures++; $display("FAIL reset_wr_en dut%0d: got %b expected 0", i, we[i]); end
            if (fd[i] !== 1'b0) begin failures++; $display("FAIL reset_frame_done dut%0d: got %b expected 0", i, fd[i]); end
            if (lc[i] !== 10'd0) begin failures++; $display("FAIL reset_line_count dut%0d: got %0d expected 0", i, lc[i]); end
            if (ov[i] !== 1'b0) begin failures++; $display("FAIL reset_overflow dut%0d: got %b expected 0", i, ov[i]); end
            if (se[i] !== 1'b0) begin failures++; $display("FAIL reset_seq_err dut%0d: got %b expected 0", i, se[i]); end
        end
        reset = 1'b1;
        capture_en = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_basic_frame();
        int fd0 [2];
        fd0 = fd_cnt;
        frame_start();
        send_line(8'h01, 4, -1);
        send_line(8'h05, 4, -1);
        frame_end();
        checks += 2;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++; $display("FAIL basic_writes: pending %0d/%0d expected 0/0", q0.size(), q1.size());
        end
        if (se[0] !== 1'b0) begin failures++; $display("FAIL basic_seq_err: got %b expected 0", se[0]); end
        for (int i = 0; i < 2; i++) begin
            checks += 3;
            if (lc[i] !== 10'(m_lines[i])) begin failures++; $display("FAIL basic_line_count dut%0d: got %0d expected %0d", i, lc[i], m_lines[i]); end
            if (fd_cnt[i] != fd0[i] + 1) begin failures++; $display("FAIL basic_frame_done dut%0d: got %0d pulses expected 1", i, fd_cnt[i] - fd0[i]); end
            if (ov[i] !== 1'b0) begin failures++; $display("FAIL basic_overflow dut%0d: got %b expected 0", i, ov[i]); end
        end
    endtask

    task automatic test_overflow();
        frame_start();
        send_line(8'h01, 4, 3);
        send_line(8'h05, 4, -1);
        frame_end();
        checks += 1;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++; $display("FAIL ovf_writes: pending %0d/%0d expected 0/0", q0.size(), q1.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks += 2;
            if (ov[i] !== m_ovf[i]) begin failures++; $display("FAIL ovf_set dut%0d: got %b expected %b", i, ov[i], m_ovf[i]); end
            if (lc[i] !== 10'd2) begin failures++; $display("FAIL ovf_line_count dut%0d: got %0d expected 2", i, lc[i]); end
        end
        frame_start();
        for (int i = 0; i < 2; i++) begin
            checks += 2;
            if (ov[i] !== 1'b0) begin failures++; $display("FAIL ovf_clear dut%0d: got %b expected 0", i, ov[i]); end
            if (lc[i] !== 10'd0) begin failures++; $display("FAIL ovf_lc_clear dut%0d: got %0d expected 0", i, lc[i]); end
        end
    endtask

    task automatic test_odd_line();
        send_line(8'h10, 5, -1);
        frame_end();
        checks += 1;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++; $display("FAIL odd_writes: pending %0d/%0d expected 0/0", q0.size(), q1.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks += 1;
            if (lc[i] !== 10'd1) begin failures++; $display("FAIL odd_line_count dut%0d: got %0d expected 1", i, lc[i]); end
        end
    endtask

    task automatic test_line_limit();
        frame_start();
        send_line(8'h30, 6, -1);
        frame_end();
        checks += 1;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++; $display("FAIL limit_writes: pending %0d/%0d expected 0/0", q0.size(), q1.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks += 1;
            if (lc[i] !== 10'd1) begin failures++; $display("FAIL limit_line_count dut%0d: got %0d expected 1", i, lc[i]); end
        end
    endtask

    task automatic test_reset_midline();
        int fd0 [2];
        frame_start();
        send_line(8'h40, 4, -1);
        line_begin();
        send_byte(8'h44, 1'b0);
        send_byte(8'h45, 1'b0);
        send_byte(8'h46, 1'b0);
        fd0 = fd_cnt;
        @(negedge clock);
        reset = 1'b0;
        armed = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks += 4;
            if (wd[i] !== 16'h0) begin failures++; $display("FAIL rst_mid_wr_data dut%0d: got %h expected 0000", i, wd[i]); end
            if (we[i] !== 1'b0) begin failures++; $display("FAIL rst_mid_wr_en dut%0d: got %b expected 0", i, we[i]); end
            if (lc[i] !== 10'd0) begin failures++; $display("FAIL rst_mid_line_count dut%0d: got %0d expected 0", i, lc[i]); end
            if (ov[i] !== 1'b0 || se[i] !== 1'b0 || fd[i] !== 1'b0) begin
                failures++; $display("FAIL rst_mid_flags dut%0d: got ov=%b se=%b fd=%b expected 0", i, ov[i], se[i], fd[i]);
            end
        end
        send_byte(8'h47, 1'b0);
        line_end();
        frame_end();
        checks += 1;
        if (fd_cnt[0] != fd0[0] || fd_cnt[1] != fd0[1] || q0.size() != 0 || q1.size() != 0) begin
            failures++; $display("FAIL rst_mid_abandon: frame_done %0d/%0d pending %0d/%0d expected 0", fd_cnt[0] - fd0[0], fd_cnt[1] - fd0[1], q0.size(), q1.size());
        end
        frame_start();
        send_line(8'h50, 2, -1);
        frame_end();
        for (int i = 0; i < 2; i++) begin
            checks += 2;
            if (lc[i] !== 10'd1) begin failures++; $display("FAIL rst_resume_lc dut%0d: got %0d expected 1", i, lc[i]); end
            if (fd_cnt[i] != fd0[i] + 1) begin failures++; $display("FAIL rst_resume_fd dut%0d: got %0d expected 1", i, fd_cnt[i] - fd0[i]); end
        end
        checks += 1;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++; $display("FAIL rst_resume_writes: pending %0d/%0d expected 0/0", q0.size(), q1.size());
        end
    endtask

    task automatic test_seq_check();
        int fd0 [2];
        fd0 = fd_cnt;
        frame_start();
        line_begin();
        send_byte(8'h20, 1'b0);
        send_byte(8'h21, 1'b0);
        send_byte(8'h23, 1'b0);
        line_end();
        for (int i = 0; i < 2; i++) begin
            checks += 1;
            if (se[i] !== EXP_SEQ) begin failures++; $display("FAIL seq_after_byte dut%0d: got %b expected %b", i, se[i], EXP_SEQ); end
        end
        frame_end();
        for (int i = 0; i < 2; i++) begin
            checks += 2;
            if (se[i] !== EXP_SEQ) begin failures++; $display("FAIL seq_after_done dut%0d: got %b expected %b", i, se[i], EXP_SEQ); end
            if (fd_cnt[i] != fd0[i] + 1) begin failures++; $display("FAIL seq_frame_done dut%0d: got %0d expected 1", i, fd_cnt[i] - fd0[i]); end
        end
        checks += 1;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++; $display("FAIL seq_writes: pending %0d/%0d expected 0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        reset      = 1'b0;
        cam_pclk   = 1'b0;
        cam_hsync  = 1'b0;
        cam_vsync  = 1'b0;
        cam_data   = 8'h00;
        capture_en = 1'b0;
        wr_full    = 1'b0;
        armed      = 1'b0;
        m_lim[0]   = 320;
        m_lim[1]   = 4;
        fd_cnt[0]  = 0;
        fd_cnt[1]  = 0;
        test_reset();
        test_basic_frame();
        test_overflow();
        test_odd_line();
        test_line_limit();
        test_reset_midline();
        test_seq_check();
        repeat (4) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_capture_packer.md
Name: cam_capture_packer

Overview:
- Downstream consumer of the camera/fake-data source. Samples the parallel camera interface (pclk, hsync, vsync, 8-bit data) in the system clock domain.
- Packs byte pairs into 16-bit words and pushes them to a frame-buffer FIFO through a write strobe.
- Tracks lines per frame and reports frame completion and FIFO overflow to the control logic.

Parameters:
- LINE_BYTES, 320, maximum bytes captured per line. Bytes beyond this count are ignored.
- LINE_W, 10, width of line_count.

Ports:
- clock  input  1  system clock; must be at least 4x the cam_pclk frequency.
- reset  input  1  synchronous, active-low reset.
- cam_pclk  input  1  camera pixel clock, sampled as data.
- cam_hsync  input  1  line valid, high during active bytes.
- cam_vsync  input  1  frame sync, high during the frame boundary.
- cam_data  input  8  pixel byte.
- capture_en  input  1  arms capture of frames.
- wr_full  input  1  FIFO full.
- wr_data  output  16  packed word, {first byte, second byte}.
- wr_en  output  1  one-cycle FIFO write strobe.
- frame_done  output  1  one-cycle pulse at the end of each captured frame.
- line_count  output  LINE_W  lines captured in the current or last frame.
- overflow  output  1  sticky flag: a word was dropped because the FIFO was full.
- seq_err  output  1  sticky sequence-check error (see Optional Feature).

Behaviour:
- Clock and reset: one clock. reset is synchronous and active-low, sampled on the posedge of clock.
  - Reset values: wr_data=0, wr_en=0, frame_done=0, line_count=0, overflow=0, seq_err=0.
  - Reset also clears the FSM to IDLE, the byte phase to 0, the byte counter to 0, and all synchronizer flops to 0.
  - Reset mid-frame abandons the frame with no write and no frame_done.
- Synchronization:
  - cam_pclk, cam_hsync and cam_vsync each pass through 2 flops, plus a third flop for edge detection.
  - cam_data passes through 2 flops, keeping it aligned with the synced pclk.
  - pclk_rise = synced high and previous low. hsync_fall and vsync_rise/vsync_fall are defined the same way.
- FSM states: IDLE, WAIT_FRAME, ACTIVE, DONE.
  - IDLE: if capture_en=1, go to WAIT_FRAME.
  - WAIT_FRAME: on vsync_fall, go to ACTIVE. Entering ACTIVE clears line_count, overflow, seq_err, byte phase and byte counter.
  - ACTIVE, byte capture: on pclk_rise with synced hsync=1 and byte counter < LINE_BYTES, capture the synced data byte and increment the byte counter.
    - Phase 0: store the byte as the high byte.
    - Phase 1: present the word and assert wr_en for exactly 1 cycle. The word appears on the cycle after the capturing pclk_rise (1-cycle latency).
    - If wr_full=1 at write time: no wr_en, word dropped, overflow set to 1.
  - ACTIVE, line end: on hsync_fall, if the byte counter > 0, increment line_count, saturating at all-ones.
    - A pending odd byte is discarded.
    - Byte phase and byte counter reset to 0.
  - ACTIVE, frame end: on vsync_rise, go to DONE. A pending odd byte is discarded.
  - DONE: assert frame_done for 1 cycle, then go to WAIT_FRAME if capture_en=1, otherwise to IDLE.
- capture_en is only sampled in IDLE and DONE. Deasserting it mid-frame lets the current frame complete.
- Simultaneous events in the same cycle:
  - hsync_fall and pclk_rise: the byte is not captured, because hsync is already low.
  - vsync_rise and hsync_fall: the line is counted first, then the FSM goes to DONE.
- line_count, overflow and seq_err hold their values after DONE until the next ACTIVE entry.
- wr_en is never asserted outside ACTIVE.

Optional Feature:
- Macro: CAPTURE_SEQ_CHECK_EN.
- Defined: in ACTIVE, each captured byte after the first of a frame must equal the previous captured byte + 1 mod 256 (the incrementing pattern of the fake source). On a mismatch, seq_err is set to 1 (sticky). It is cleared on ACTIVE entry and on reset.
- Undefined: seq_err is tied to 0 and no checker logic is synthesized.

Test Plan:
1. Reset, then capture_en=1. Drive 1 frame of 2 lines x 4 bytes, bytes 0x01..0x08, with pclk period 8 clocks. Required:
   - 4 wr_en pulses with wr_data 0x0102, 0x0304, 0x0506, 0x0708.
   - line_count=2 and one frame_done pulse.
   - overflow=0 and seq_err=0.
2. Same frame with wr_full=1 during the 2nd word. Required: 3 writes (0x0102, 0x0506, 0x0708), overflow=1 at frame_done, and overflow cleared at the next vsync_fall.
3. Line of 5 bytes 0x10..0x14. Required: writes 0x1011 and 0x1213 only; 0x14 is discarded and line_count increments by 1.
4. LINE_BYTES=4, line of 6 bytes. Required: only 2 writes; bytes 5 and 6 are ignored.
5. Assert reset low for 1 cycle mid-line after 3 bytes. Required: all outputs return to 0 the next cycle, with no frame_done and no wr_en. With capture_en still 1, capture resumes at the next vsync_fall.
6. With CAPTURE_SEQ_CHECK_EN defined, byte stream 0x20, 0x21, 0x23. Required: seq_err=1 after the third byte and stays set through frame_done. With the macro undefined, seq_err stays 0.
